seg_value_encoder: RTL and testbench
====================================

# seg_value_encoder

Converts a 16-bit value into four 7-segment patterns, one per digit, for the 4-digit anode-scanning multiplexer directly downstream. Decimal mode runs an iterative shift-and-add-3 binary-to-BCD conversion. Hex mode decodes nibbles directly. Results load into registered per-digit pattern outputs that hold steady between updates, so the scanning stage never sees a partial result.

## Interface

Parameters:
- BLANK_LEADING, default 1: when 1, leading zero digits are blanked in decimal mode.

Ports:
- clk  input  1  system clock; one clock for the whole block
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only when busy=0
- value  input  16  unsigned value, sampled on the accepting edge
- hex_mode  input  1  1 = hexadecimal display, 0 = decimal; sampled with value
- busy  output  1  high while a conversion is in progress (state != IDLE)
- done  output  1  one-cycle pulse; pattern outputs updated on the same edge
- seg_out_1  output  8  rightmost digit (ones / nibble 0) pattern
- seg_out_2  output  8  digit 2 pattern
- seg_out_3  output  8  digit 3 pattern
- seg_out_4  output  8  leftmost digit pattern

## Operation

Pattern format:
- Segments are active-low; 0 lights a segment.
- Bit order is {dp,g,f,e,d,c,b,a}. dp is always 1 (off).

Digit codes:
- 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
- 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Blank = FF. Dash = BF.

State machine: IDLE, SHIFT, ENCODE.
- IDLE with start=1: capture value and hex_mode.
  - Hex mode, or decimal with value > 9999: go to ENCODE.
  - Otherwise: clear the 16-bit BCD register, load the 16-bit shift register, set the iteration counter to 0, go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {bcd, shreg} left by 1.
  - Increment the counter.
  - After the 16th iteration (counter = 15 on entry), go to ENCODE.
- ENCODE: register all four seg_out, assert done for one cycle, return to IDLE.
- start while busy=1 is ignored. It is not queued.

Encoding rules:
- Hex mode: digit n shows nibble n of the value. No blanking.
- Decimal, value ≤ 9999: digit n shows BCD nibble n.
  - With BLANK_LEADING=1, zero digits above the most significant non-zero digit show FF.
  - seg_out_1 is never blanked, so 0 displays as "   0".
- Decimal, value > 9999: all four digits show BF (overflow dashes).
- BCD nibbles beyond 9 cannot occur; the decoder maps them to FF.

## Timing

Edge numbering: E0 is the edge at which start is accepted.
- Decimal path:
  - busy is high after E0.
  - SHIFT occupies E1..E16.
  - Outputs update and done=1 at E17; busy drops at E17.
  - Latency is 17 cycles from acceptance.
- Hex and overflow paths:
  - Outputs update and done=1 at E1.
  - busy is high for exactly one cycle.
- A start in the cycle where done=1 is accepted, since state is IDLE. Back-to-back decimal conversions therefore have an 18-cycle period.
- seg_out change only on done edges. They are stable otherwise.

Reset:
- Values: state IDLE, busy 0, done 0, all seg_out FF, BCD/shift registers and counter 0.
- Reset asserted mid-conversion aborts it. No done is produced, and outputs go to FF at the reset edge.
- Reset dominates a simultaneous start.

## Test plan

- Decimal 1234, BLANK_LEADING=1 -> done exactly 17 cycles after acceptance; seg_out_4..1 = F9, A4, B0, 99; busy high 17 cycles.
- Decimal 42, then decimal 0 -> seg_out_4..1 = FF, FF, 99, A4; then FF, FF, FF, C0. With BLANK_LEADING=0, 42 -> C0, C0, 99, A4.
- Decimal 10000 and 65535 -> all outputs BF, done 1 cycle after acceptance. Decimal 9999 -> all 90 after 17 cycles.
- Hex 0xBEEF -> seg_out_4..1 = 83, 86, 86, 8E at 1-cycle latency. Hex 0x000A -> C0, C0, C0, 88 (no blanking).
- Start pulsed with 5555 at E5 of a 1234 conversion -> ignored; result 1234 with a single done. Start in the done cycle with 7 -> accepted; FF, FF, FF, F8 after 17 more cycles.
- Reset asserted at E8 of a decimal conversion -> no done; outputs FF, busy 0 next cycle. A following conversion of 808 -> FF, 80, C0, 80.

Source files
------------

// File: rtl/seg_value_encoder_if.sv
// Request/result bundle between a value producer and seg_value_encoder.
// The master drives the request and the encoder (slave) returns status and patterns.
interface seg_value_encoder_if;
    logic        start;
    logic [15:0] value;
    logic        hex_mode;
    logic        busy;
    logic        done;
    logic [7:0]  seg_out_1;
    logic [7:0]  seg_out_2;
    logic [7:0]  seg_out_3;
    logic [7:0]  seg_out_4;

    modport master (
        output start, value, hex_mode,
        input  busy, done, seg_out_1, seg_out_2, seg_out_3, seg_out_4
    );

    modport slave (
        input  start, value, hex_mode,
        output busy, done, seg_out_1, seg_out_2, seg_out_3, seg_out_4
    );
endinterface

// File: rtl/seg_value_encoder.sv
// 16-bit value to four active-low 7-segment patterns: decimal via iterative
// shift-and-add-3, hex by direct nibble decode; patterns are held between updates.
module seg_value_encoder #(
    parameter int BLANK_LEADING = 1
) (
    input  logic               clk,
    input  logic               reset,
    seg_value_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [7:0]  SEG_BLANK = 8'hFF;
    localparam logic [7:0]  SEG_DASH  = 8'hBF;
    localparam logic [15:0] DEC_MAX   = 16'd9999;

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_value;
    logic            r_hex;
    logic [15:0]     r_bcd;
    logic [15:0]     r_shreg;
    logic [3:0]      r_cnt;
    logic            r_done;
    logic [3:0][7:0] r_seg;

    logic            w_accept;
    logic            w_direct;
    logic            w_encode;
    logic [15:0]     w_bcd_adj;
    logic [3:0][7:0] w_seg;

    function automatic logic [7:0] hex_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // A BCD digit above 9 is impossible after a correct conversion; show it blank.
    function automatic logic [7:0] dec_code(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : hex_code(d);
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Hex requests and out-of-range decimal values skip the BCD conversion.
    assign w_direct = bus.hex_mode || (bus.value > DEC_MAX);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_encode     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_direct ? ENCODE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == 4'd15) begin
                    w_next_state = ENCODE;
                end
            end
            ENCODE: begin
                w_encode     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            w_bcd_adj[4*i +: 4] = add3(r_bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_hex   <= 1'b0;
            r_bcd   <= '0;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_seg   <= {4{SEG_BLANK}};
        end else begin
            r_done <= w_encode;
            if (w_accept) begin
                r_value <= bus.value;
                r_hex   <= bus.hex_mode;
                if (!w_direct) begin
                    r_bcd   <= '0;
                    r_shreg <= bus.value;
                    r_cnt   <= '0;
                end
            end
            if (r_state == SHIFT) begin
                {r_bcd, r_shreg} <= {w_bcd_adj, r_shreg} << 1;
                r_cnt            <= r_cnt + 4'd1;
            end
            if (w_encode) begin
                r_seg <= w_seg;
            end
        end
    end

    // Pattern selection from the captured request and the finished BCD digits.
    always_comb begin
        w_seg = {4{SEG_BLANK}};
        if (r_hex) begin
            for (int i = 0; i < 4; i++) begin
                w_seg[i] = hex_code(r_value[4*i +: 4]);
            end
        end else if (r_value > DEC_MAX) begin
            w_seg = {4{SEG_DASH}};
        end else begin
            for (int i = 0; i < 4; i++) begin
                w_seg[i] = dec_code(r_bcd[4*i +: 4]);
            end
            if (BLANK_LEADING != 0) begin
                if (r_bcd[15:12] == 4'd0) w_seg[3] = SEG_BLANK;
                if (r_bcd[15:8]  == 8'd0) w_seg[2] = SEG_BLANK;
                if (r_bcd[15:4]  == 12'd0) w_seg[1] = SEG_BLANK;
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.seg_out_1 = r_seg[0];
    assign bus.seg_out_2 = r_seg[1];
    assign bus.seg_out_3 = r_seg[2];
    assign bus.seg_out_4 = r_seg[3];
endmodule

// File: tb/tb_seg_value_encoder.sv
// Self-checking bench for seg_value_encoder: two instances (leading-zero blanking on/off)
// driven identically, compared against an arithmetic reference model.
module tb_seg_value_encoder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_value_encoder_if bus_blank ();
    seg_value_encoder_if bus_full ();

    seg_value_encoder #(.BLANK_LEADING(1)) u_dut_blank (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_blank.slave)
    );

    seg_value_encoder #(.BLANK_LEADING(0)) u_dut_full (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_full.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_codes [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic [31:0] segs_blank;
    logic [31:0] segs_full;
    assign segs_blank = {bus_blank.seg_out_4, bus_blank.seg_out_3, bus_blank.seg_out_2, bus_blank.seg_out_1};
    assign segs_full  = {bus_full.seg_out_4, bus_full.seg_out_3, bus_full.seg_out_2, bus_full.seg_out_1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Display expected for {digit4, digit3, digit2, digit1}, from decimal/hex arithmetic.
    function automatic logic [31:0] model(input int v, input bit h, input bit blank);
        logic [31:0] r;
        logic [7:0]  s;
        int          p;
        r = '0;
        p = 1;
        for (int n = 0; n < 4; n++) begin
            if (h)
                s = seg_codes[(v >> (4 * n)) & 15];
            else if (v > 9999)
                s = 8'hBF;
            else if (blank && n > 0 && v < p)
                s = 8'hFF;
            else
                s = seg_codes[(v / p) % 10];
            r[8*n +: 8] = s;
            p = p * 10;
        end
        return r;
    endfunction

    // Pattern outputs may only move on a done cycle or right after a reset edge.
    bit          rst_q = 1'b1;
    logic [31:0] prev_blank = 32'hFFFF_FFFF;
    logic [31:0] prev_full  = 32'hFFFF_FFFF;

    always @(posedge clk) rst_q = reset;

    always @(negedge clk) begin
        if (segs_blank !== prev_blank || segs_full !== prev_full)
            check("seg_stable", {31'b0, (bus_blank.done & bus_full.done) | rst_q}, 32'd1);
        prev_blank = segs_blank;
        prev_full  = segs_full;
    end

    task automatic drive(input logic s, input logic [15:0] v, input logic h);
        bus_blank.start    = s;
        bus_full.start     = s;
        bus_blank.value    = v;
        bus_full.value     = v;
        bus_blank.hex_mode = h;
        bus_full.hex_mode  = h;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge (E0).
    task automatic launch(input logic [15:0] v, input logic h);
        @(negedge clk);
        drive(1'b1, v, h);
        @(posedge clk);
        #1;
        drive(1'b0, v, h);
    endtask

    // Counts edges from E(k0) until done; lat is the edge index of done, -1 on timeout.
    task automatic wait_done(input int k0, output int lat, output int bcyc);
        lat  = -1;
        bcyc = 0;
        for (int k = k0 + 1; k <= k0 + 40; k++) begin
            if (bus_blank.busy) bcyc++;
            @(posedge clk);
            #1;
            if (bus_blank.done) begin
                lat = k;
                break;
            end
        end
        check("done_pair", {31'b0, bus_full.done}, {31'b0, lat >= 0});
    endtask

    task automatic expect_result(input int v, input bit h);
        check($sformatf("seg_blank v=%0d h=%0d", v, h), segs_blank, model(v, h, 1'b1));
        check($sformatf("seg_full v=%0d h=%0d", v, h), segs_full, model(v, h, 1'b0));
        check("busy_at_done", {31'b0, bus_blank.busy}, 32'd0);
    endtask

    task automatic run_conv(input int v, input bit h);
        int lat;
        int bcyc;
        int exp_lat;
        exp_lat = (h || v > 9999) ? 1 : 17;
        launch(v[15:0], h);
        wait_done(0, lat, bcyc);
        check($sformatf("latency v=%0d", v), lat, exp_lat);
        check($sformatf("busy_cycles v=%0d", v), bcyc, exp_lat);
        expect_result(v, h);
        @(posedge clk);
        #1;
        check("done_pulse", {31'b0, bus_blank.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int lat;
        int bcyc;
        int nd;
        int v;
        bit h;

        reset = 1'b1;
        drive(1'b0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, bus_blank.busy}, 32'd0);
        check("reset_done", {31'b0, bus_blank.done}, 32'd0);
        check("reset_seg_blank", segs_blank, 32'hFFFF_FFFF);
        check("reset_seg_full", segs_full, 32'hFFFF_FFFF);
        reset = 1'b0;

        run_conv(1234, 1'b0);
        run_conv(42, 1'b0);
        run_conv(0, 1'b0);
        run_conv(10000, 1'b0);
        run_conv(65535, 1'b0);
        run_conv(9999, 1'b0);
        run_conv(16'hBEEF, 1'b1);
        run_conv(16'h000A, 1'b1);

        // A start during a conversion is dropped; a start in the done cycle is taken.
        launch(16'd1234, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        drive(1'b1, 16'd5555, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'd0, 1'b0);
        wait_done(5, lat, bcyc);
        check("ignored_start_latency", lat, 17);
        expect_result(1234, 1'b0);
        launch(16'd7, 1'b0);
        wait_done(0, lat, bcyc);
        check("back_to_back_latency", lat, 17);
        expect_result(7, 1'b0);

        // Reset at E8 aborts the conversion with no done.
        launch(16'd1234, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'b0, bus_blank.busy}, 32'd0);
        check("abort_done", {31'b0, bus_blank.done}, 32'd0);
        check("abort_seg_blank", segs_blank, 32'hFFFF_FFFF);
        check("abort_seg_full", segs_full, 32'hFFFF_FFFF);
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus_blank.done || bus_full.done) nd++;
        end
        check("abort_no_done", nd, 0);
        run_conv(808, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 65535));
            endcase
            h = bit'($urandom_range(0, 1));
            run_conv(v, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
